// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the multicycle CPU.
// The multiplier and divider both size their operands from XLEN.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITER  = XLEN;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract,
// and keep the difference only when it does not go negative.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              in_bit,
    input  logic [DATA_W-1:0] dvsr,
    output logic [DATA_W-1:0] next_rem,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // rem stays below dvsr <= 2^(DATA_W-1), so one extra bit is enough
    // for the sign of the trial difference to be exact.
    always_comb begin
        shifted  = {rem, in_bit};
        trial    = shifted - {1'b0, dvsr};
        q_bit    = ~trial[DATA_W];
        next_rem = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider (MIPS DIV semantics): one restoring step per clock,
// remainder to hi, quotient to lo, divide-by-zero flagged in the DONE cycle.
module div_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W = DIV_ITER,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    div_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvsr;
    logic              neg_quo;
    logic              neg_rem;

    logic              accept;
    logic              by_zero;
    logic [DATA_W-1:0] step_rem;
    logic              step_bit;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem),
        .in_bit   (quo[DATA_W-1]),
        .dvsr     (dvsr),
        .next_rem (step_rem),
        .q_bit    (step_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        by_zero   = (divisor == '0);
        unique case (state)
            IDLE, DONE: begin
                accept = start;
                if (start) begin
                    state_nxt = by_zero ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN:     state_nxt = (cnt == '0) ? FIX : RUN;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy     <= (state_nxt == RUN) || (state_nxt == FIX);
            done     <= (state_nxt == DONE);
            div_zero <= accept && by_zero;
            unique case (state)
                IDLE, DONE: begin
                    if (accept && !by_zero) begin
                        dvsr    <= mag(divisor);
                        quo     <= mag(dividend);
                        rem     <= '0;
                        neg_quo <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
                        neg_rem <= dividend[DATA_W-1];
                        cnt     <= CNT_W'(DATA_W - 1);
                    end
                end
                RUN: begin
                    rem <= step_rem;
                    quo <= {quo[DATA_W-2:0], step_bit};
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    // 0x80000000 / -1 wraps back to 0x80000000 here by design.
                    lo <= neg_quo ? (~quo + 1'b1) : quo;
                    hi <= neg_rem ? (~rem + 1'b1) : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: signed cases, divide by zero,
// overflow wrap, ignored start while busy, and asynchronous reset mid-run.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_pass  = 0;
    int n_total = 0;
    int cyc;

    div_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Drive a request before an edge; return 1 time unit after the accepting edge E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic divide(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int cycles;
        int busy_cycles;
        issue(a, b);
        check({tag, "_done_low_after_e0"}, {31'b0, done}, 32'd0);
        cycles      = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'd33);
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_div_zero"}, {31'b0, div_zero}, 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_div_zero", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        divide("7_div_2", 32'd7, 32'd2, 32'h0000_0003, 32'h0000_0001);

        // Issued during the DONE cycle of 7/2: accepted back-to-back.
        issue(32'd100, 32'd0);
        check("dz_done", {31'b0, done}, 32'd1);
        check("dz_flag", {31'b0, div_zero}, 32'd1);
        check("dz_busy", {31'b0, busy}, 32'd0);
        check("dz_hi_kept", hi, 32'h0000_0001);
        check("dz_lo_kept", lo, 32'h0000_0003);
        @(posedge clk);
        #1;
        check("dz_done_pulse", {31'b0, done}, 32'd0);
        check("dz_flag_pulse", {31'b0, div_zero}, 32'd0);

        divide("m7_div_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        divide("7_div_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
        divide("m100_div_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE);
        divide("min_div_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
        divide("0_div_5", 32'd0, 32'd5, 32'h0000_0000, 32'h0000_0000);

        // A second start mid-RUN must be dropped without disturbing 1000/7.
        issue(32'd1000, 32'd7);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (cyc == 5) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check("ignore_latency", 32'(cyc), 32'd33);
        check("ignore_lo", lo, 32'd142);
        check("ignore_hi", hi, 32'd6);

        // Asynchronous reset between edges during RUN.
        issue(32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_div_zero", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        divide("9_div_3", 32'd9, 32'd3, 32'h0000_0003, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential signed 32-bit divider for the multicycle CPU datapath. It sits directly upstream of the Hi/Lo select muxes. It takes the A/B operands (or MDR) chosen by the DIVASelect/DIVBSelect muxes, runs one restoring iteration per clock, and produces the remainder for Hi and the quotient for Lo. A divide-by-zero flag goes to the control unit so it can raise the exception.

## Interface
- DATA_W, 32, operand/result width; only 32 is supported, other values are for test only
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset); one clock domain only
- start  in  1  request a divide; sampled only in IDLE or DONE
- dividend  in  DATA_W  signed dividend; sampled on the accepting edge only
- divisor  in  DATA_W  signed divisor; sampled on the accepting edge only
- hi  out  DATA_W  remainder; registered, holds until the next successful completion
- lo  out  DATA_W  quotient; registered, holds until the next successful completion
- busy  out  1  high in RUN and FIX
- done  out  1  one-cycle pulse in DONE
- div_zero  out  1  high in DONE when the operation was a divide by zero; 0 otherwise

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + start=1:
  - divisor==0: go to DONE with div_zero=1. hi and lo are unchanged.
  - otherwise: latch |dividend| and |divisor| as unsigned, latch both sign bits, clear the partial remainder, set cnt=DATA_W-1, go to RUN.
- IDLE/DONE + start=0: DONE returns to IDLE; IDLE stays in IDLE.
- RUN, one restoring step per cycle:
  - Shift {rem, quo} left by 1, bringing in the MSB of the working dividend.
  - Compute trial = rem - |divisor| at DATA_W+1 bits.
  - If trial is non-negative, rem = trial and quo LSB = 1; otherwise quo LSB = 0.
  - When cnt==0, go to FIX; otherwise cnt decrements.
- FIX:
  - lo = quo, negated (two's complement) when the sign bits differ.
  - hi = rem, negated when the dividend was negative.
  - Go to DONE.
- Semantics are MIPS DIV: quotient truncates toward zero, and the remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF: the magnitude quotient 2^31 wraps, so lo=0x80000000 and hi=0. No flag is raised.
- start while busy is ignored with no queuing. dividend and divisor may change freely after the accepting edge.
- reset=0 at any time, including mid-RUN, asynchronously forces:
  - state IDLE
  - hi=lo=0, busy=done=div_zero=0
  - all internal registers 0

## Timing
- Call the accepting edge E0.
- busy is high from after E0 until after E32; RUN covers edges E1..E32.
- FIX occupies the cycle after E32.
- E33 loads hi and lo and enters DONE, so done=1 for the one cycle after E33.
- Latency is 33 clocks from the start edge to valid hi/lo with done high.
- Divide by zero: done=1 and div_zero=1 in the cycle after E0, so latency is 1.
- Back-to-back: start=1 during the DONE cycle is accepted at the next edge with no idle bubble. done is not re-asserted until that operation completes.
- hi and lo change only on the FIX→DONE edge, so Hi/Lo may load them in the done cycle.
- All outputs are registered. No combinational path runs from an input to an output.

## Structure
- Shared package cpu_pkg holds:
  - enum div_state_t {IDLE, RUN, FIX, DONE}
  - localparam DIV_ITER = 32
  - the width constants shared with the multiplier
- One combinational sub-module, div_step. It takes rem, the incoming bit and the divisor magnitude, and returns next_rem and q_bit. It is instantiated once.
- The FSM, counter and sign fix-up stay in div_seq.

## Test plan
- 7 / 2, start at E0 → done after E33; lo=0x00000003, hi=0x00000001; busy high for exactly 33 cycles.
- -7 (0xFFFFFFF9) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 7 / -2 → lo=0xFFFFFFFD, hi=0x00000001.
- 100 / 0 issued after the 7/2 case → done and div_zero high one cycle after E0; hi=1 and lo=3 unchanged; the next valid divide clears div_zero.
- 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0x00000000, div_zero=0. Also 0 / 5 → lo=0, hi=0.
- Start 1000/7, pulse start=1 again with 9/3 at RUN cycle 5 → the second start is ignored; result is lo=142 (0x8E), hi=6.
- Start 1000/7, drive reset=0 mid-edge at RUN cycle 10 → hi, lo, busy, done and div_zero go to 0 immediately with no clock. After release, 9/3 completes normally with lo=3, hi=0 in 33 cycles.
